// File: rtl/fp32_stream_accumulator.sv
// fp32_stream_accumulator
//   Sums a stream of fp32 products (from the fp32 multiplier) into one fp32
//   result per stream. One operand is taken every 4 cycles through a
//   multicycle ALIGN/ADD/NORM datapath. The arithmetic matches the multiplier:
//   denormals flush to zero, results truncate toward zero, and there is no
//   NaN/Inf special-casing on the inputs.
//
// Ports
//   clk_n      falling-edge clock (all flops update on negedge)
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_data    fp32 operand
//   in_last    operand is the final term of the stream
//   in_ready   accumulator can take an operand (IDLE only, low in reset)
//   out_valid  accumulated result valid (held until out_ready)
//   out_data   fp32 accumulated sum
//   out_count  number of terms in the stream (wraps at 2^COUNT_W)
//   out_ready  consumer takes the result
//
// States
//   state | meaning
//   IDLE  | waiting for an operand, in_ready high
//   ALIGN | pick big/small operand, right-shift small mantissa
//   ADD   | add or subtract aligned mantissas
//   NORM  | normalise, truncate, write accumulator
//   OUT   | present result until out_ready

module fp32_stream_accumulator #(
  parameter int COUNT_W = 16
) (
  input  logic               clk_n,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] out_count,
  input  logic               out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [31:0]        op_q, op_d;
  logic               last_q, last_d;

  logic               big_sign_q, big_sign_d;
  logic [7:0]         big_exp_q, big_exp_d;
  logic [26:0]        big_mant_q, big_mant_d;
  logic [26:0]        small_mant_q, small_mant_d;
  logic               sub_q, sub_d;
  logic [27:0]        sum_q, sum_d;

  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;

  // Leading-zero count over a 27-bit mantissa; the highest set bit wins.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // ALIGN datapath: decode both operands (exp==0 flushes to zero, sign
  // ignored since a zero mantissa can never survive to the result sign).
  // ---------------------------------------------------------------------------
  logic [7:0]  acc_exp, op_exp, b_exp, s_exp, exp_diff;
  logic [23:0] acc_mant, op_mant, b_mant, s_mant;
  logic        acc_big, b_sign, s_sign;
  logic [26:0] s_aligned;

  always_comb begin
    acc_exp  = acc_q[30:23];
    op_exp   = op_q[30:23];
    acc_mant = (acc_exp == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
    op_mant  = (op_exp == 8'd0) ? 24'd0 : {1'b1, op_q[22:0]};
    // Ties go to the accumulator so equal magnitudes cancel with its sign.
    acc_big  = {acc_exp, acc_mant} >= {op_exp, op_mant};
    b_exp    = acc_big ? acc_exp  : op_exp;
    b_mant   = acc_big ? acc_mant : op_mant;
    b_sign   = acc_big ? acc_q[31] : op_q[31];
    s_exp    = acc_big ? op_exp   : acc_exp;
    s_mant   = acc_big ? op_mant  : acc_mant;
    s_sign   = acc_big ? op_q[31] : acc_q[31];
    exp_diff = b_exp - s_exp;
    if (exp_diff >= 8'd27) s_aligned = 27'd0;
    else                   s_aligned = {s_mant, 3'b000} >> exp_diff;
  end

  // ---------------------------------------------------------------------------
  // NORM datapath
  // ---------------------------------------------------------------------------
  logic [4:0]        lz;
  logic [23:0]       norm_mant;
  logic signed [9:0] norm_exp;
  logic [31:0]       norm_res;

  always_comb begin
    lz = lzc27(sum_q[26:0]);
    if (sum_q[27]) begin
      norm_mant = sum_q[27:4];
      norm_exp  = $signed({2'b00, big_exp_q}) + 10'sd1;
    end else begin
      norm_mant = 24'((sum_q[26:0] << lz) >> 3);
      norm_exp  = $signed({2'b00, big_exp_q}) - $signed({5'b00000, lz});
    end

    if (sum_q == 28'd0)             norm_res = 32'h0000_0000;
    else if (norm_exp <= 10'sd0)    norm_res = 32'h0000_0000;
    else if (norm_exp >= 10'sd255)  norm_res = {big_sign_q, 8'hFF, 23'd0};
    else                            norm_res = {big_sign_q, norm_exp[7:0], norm_mant[22:0]};
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    op_d         = op_q;
    last_d       = last_q;
    big_sign_d   = big_sign_q;
    big_exp_d    = big_exp_q;
    big_mant_d   = big_mant_q;
    small_mant_d = small_mant_q;
    sub_d        = sub_q;
    sum_d        = sum_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          last_d  = in_last;
          count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        big_sign_d   = b_sign;
        big_exp_d    = b_exp;
        big_mant_d   = {b_mant, 3'b000};
        small_mant_d = s_aligned;
        sub_d        = b_sign ^ s_sign;
        state_d      = S_ADD;
      end
      S_ADD: begin
        if (sub_q) sum_d = {1'b0, big_mant_q} - {1'b0, small_mant_q};
        else       sum_d = {1'b0, big_mant_q} + {1'b0, small_mant_q};
        state_d = S_NORM;
      end
      S_NORM: begin
        acc_d = norm_res;
        if (last_q) begin
          out_valid_d = 1'b1;
          out_data_d  = norm_res;
          out_count_d = count_q;
          state_d     = S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = 32'h0000_0000;
          count_d     = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= 32'h0000_0000;
      count_q      <= '0;
      op_q         <= 32'h0000_0000;
      last_q       <= 1'b0;
      big_sign_q   <= 1'b0;
      big_exp_q    <= 8'd0;
      big_mant_q   <= 27'd0;
      small_mant_q <= 27'd0;
      sub_q        <= 1'b0;
      sum_q        <= 28'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0000_0000;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      op_q         <= op_d;
      last_q       <= last_d;
      big_sign_q   <= big_sign_d;
      big_exp_q    <= big_exp_d;
      big_mant_q   <= big_mant_d;
      small_mant_q <= small_mant_d;
      sub_q        <= sub_d;
      sum_q        <= sum_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
    end
  end

  // Gated with rst_n so upstream never sees ready while the block is held.
  assign in_ready  = (state_q == S_IDLE) & rst_n;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_fp32_stream_accumulator.sv
module tb_fp32_stream_accumulator;

  localparam int CW = 16;

  logic          clk_n = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = 32'h0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [CW-1:0] out_count;

  fp32_stream_accumulator #(.COUNT_W(CW)) dut (
    .clk_n     (clk_n),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  always #5 clk_n = ~clk_n;

  typedef struct {
    int              n;
    logic [3:0][31:0] ops;
    logic [31:0]     exp_data;
    logic [CW-1:0]   exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0]   data;
    logic [CW-1:0] cnt;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] e, input logic [CW-1:0] cnt);
    vecs[idx].n        = n;
    vecs[idx].ops[0]   = a;
    vecs[idx].ops[1]   = b;
    vecs[idx].ops[2]   = c;
    vecs[idx].ops[3]   = d;
    vecs[idx].exp_data = e;
    vecs[idx].exp_cnt  = cnt;
  endtask

  // Presents one operand (called just after a falling edge) and returns just
  // after the falling edge that accepted it; lows counts not-ready samples.
  task automatic send_op(input logic [31:0] d, input logic last, output int lows);
    bit acc;
    acc = 1'b0;
    lows = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clk_n);
      if (in_ready) acc = 1'b1;
      else begin
        lows++;
        @(negedge clk_n);
        #1;
      end
    end
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end else begin
      @(negedge clk_n);
      #1;
    end
  endtask

  // Waits for out_valid, pops the scoreboard and compares; lat counts
  // falling edges from the call until the result is visible.
  task automatic collect(input string name, output int lat);
    bit   got;
    exp_t e;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk_n);
      if (out_valid) got = 1'b1;
      else begin
        @(negedge clk_n);
        lat++;
      end
    end
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1", name);
    end else if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_unexpected: result %h with empty scoreboard", name, out_data);
    end else begin
      e = sb.pop_front();
      check({name, "_data"}, out_data, e.data);
      check({name, "_count"}, 32'(out_count), 32'(e.cnt));
    end
    @(negedge clk_n);
    #1;
  endtask

  task automatic run_vec(input int idx);
    int lows;
    int lat;
    sb.push_back('{vecs[idx].exp_data, vecs[idx].exp_cnt});
    for (int i = 0; i < vecs[idx].n; i++) begin
      send_op(vecs[idx].ops[i], i == vecs[idx].n - 1, lows);
      if (i > 0) check($sformatf("v%0d_ready_low", idx), 32'(lows), 32'd3);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect($sformatf("v%0d", idx), lat);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'd3);
  endtask

  initial begin
    int lows;
    int lat;
    bit got;

    set_vec(0, 2, 32'h3F800000, 32'h40000000, 32'h0, 32'h0, 32'h40400000, 16'd2);
    set_vec(1, 2, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 32'h00000000, 16'd2);
    set_vec(2, 2, 32'h3FC00000, 32'h30800000, 32'h0, 32'h0, 32'h3FC00000, 16'd2);
    set_vec(3, 1, 32'h00400000, 32'h0, 32'h0, 32'h0, 32'h00000000, 16'd1);
    set_vec(4, 4, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40000000, 16'd4);
    set_vec(5, 2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h0, 32'h7F800000, 16'd2);
    set_vec(6, 2, 32'h3F800000, 32'h3F7FFFFF, 32'h0, 32'h0, 32'h3FFFFFFF, 16'd2);
    set_vec(7, 2, 32'h40400000, 32'hC0000000, 32'h0, 32'h0, 32'h3F800000, 16'd2);
    set_vec(8, 1, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h00000000, 16'd1);
    set_vec(9, 2, 32'h3F800000, 32'hC0000000, 32'h0, 32'h0, 32'hBF800000, 16'd2);
    set_vec(10, 2, 32'h00C00000, 32'h80800000, 32'h0, 32'h0, 32'h00000000, 16'd2);

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_count", 32'(out_count), 32'd0);
    @(negedge clk_n);
    #1;
    rst_n = 1'b1;
    @(posedge clk_n);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk_n);
    #1;

    for (int v = 0; v < 11; v++) run_vec(v);

    // Result held with out_ready low.
    out_ready = 1'b0;
    sb.push_back('{32'h3F800000, 16'd1});
    send_op(32'h3F800000, 1'b1, lows);
    in_valid = 1'b0;
    in_last  = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_n);
      if (out_valid) got = 1'b1;
    end
    check("hold_seen", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_n);
      @(posedge clk_n);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, 32'h3F800000);
      check("hold_count", 32'(out_count), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk_n);
    #1;
    out_ready = 1'b1;
    collect("hold", lat);
    @(posedge clk_n);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk_n);
    #1;

    // Reset while the next stream is in ALIGN.
    send_op(32'h40000000, 1'b0, lows);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_data", out_data, 32'h0);
    in_valid = 1'b0;
    @(negedge clk_n);
    @(negedge clk_n);
    #1;
    rst_n = 1'b1;
    set_vec(0, 1, 32'h40000000, 32'h0, 32'h0, 32'h0, 32'h40000000, 16'd1);
    run_vec(0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
